fifo_stream_reader: RTL and testbench

// - Read-side companion of the synchronous FIFO. Drains the FIFO's empty/data/pop interface and presents a registered valid/ready stream.
// - 2-entry output buffer (head + skid): pop_o never depends combinationally on ready_i, which breaks the consumer->FIFO timing path.
// - Sits between any sync FIFO instance and a downstream valid/ready consumer (e.g. decode or LSU request path).

---
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Stream interface for fifo_stream_reader: FIFO read side (empty/data/pop) plus
// the registered valid/ready output stream and its occupancy.
interface fifo_stream_reader_if #(
  parameter type dtype = logic [31:0]
);
  logic       fifo_empty;
  dtype       fifo_data;
  logic       fifo_pop;
  logic       valid;
  logic       ready;
  dtype       data;
  logic [1:0] occupancy;

  modport master (
    input  fifo_empty, fifo_data, ready,
    output fifo_pop, valid, data, occupancy
  );

  modport slave (
    output fifo_empty, fifo_data, ready,
    input  fifo_pop, valid, data, occupancy
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO into a 2-entry (head + skid) registered valid/ready stream.
// Optional pop statistics counter enabled by `define FIFO_READER_STATS_EN.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter type         dtype       = logic [DATA_WIDTH-1:0],
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  fifo_stream_reader_if.master   bus
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] pop_count_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  dtype   head_q, head_d;
  dtype   skid_q, skid_d;
  logic   enq, deq;

  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("COUNT_WIDTH must be at least 1");
  end

  // Pop depends only on registered state, never on ready, so the consumer
  // path does not reach back into the FIFO.
  assign enq          = rst_ni & ~flush_i & ~bus.fifo_empty & (state_q != FULL);
  assign deq          = (state_q != EMPTY) & bus.ready;

  assign bus.fifo_pop  = enq;
  assign bus.valid     = (state_q != EMPTY);
  assign bus.data      = head_q;
  assign bus.occupancy = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d = ONE;
            head_d  = bus.fifo_data;
          end
        end
        ONE: begin
          if (enq && deq) begin
            head_d = bus.fifo_data;
          end else if (enq) begin
            state_d = FULL;
            skid_d  = bus.fifo_data;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Saturating pop counter; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pop_count_o <= '0;
    end else if (enq && (pop_count_o != '1)) begin
      pop_count_o <= pop_count_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: directed scenarios plus a random
// run, all checked against a queue-based model of source FIFO and buffer.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  fifo_stream_reader_if #(.dtype(logic [31:0])) bus ();

`ifdef FIFO_READER_STATS_EN
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;
  logic [CW-1:0] pop_count;
  int            exp_cnt = 0;

  fifo_stream_reader #(
    .DATA_WIDTH (32),
    .dtype      (logic [31:0]),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .bus        (bus.master),
    .pop_count_o(pop_count)
  );
`else
  fifo_stream_reader #(
    .DATA_WIDTH(32),
    .dtype     (logic [31:0])
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus.master)
  );
`endif

  always #5 clk = ~clk;

  logic [31:0] src[$];
  logic [31:0] mbuf[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic        pre_pop, pre_valid, exp_pop;
  logic [31:0] pre_data;

  // One clock cycle: apply inputs at posedge+2, sample combinational outputs,
  // advance the model on the edge, return at the following posedge+2.
  task automatic tick(input logic fl, input logic rdy);
    flush          = fl;
    bus.ready      = rdy;
    bus.fifo_empty = (src.size() == 0);
    bus.fifo_data  = (src.size() != 0) ? src[0] : $urandom;
    #2;
    pre_pop   = bus.fifo_pop;
    pre_valid = bus.valid;
    pre_data  = bus.data;
    exp_pop   = !fl && (src.size() != 0) && (mbuf.size() < 2);
    @(posedge clk);
    if (fl) begin
      mbuf.delete();
    end else begin
      if ((mbuf.size() != 0) && rdy) void'(mbuf.pop_front());
      if (exp_pop) mbuf.push_back(src.pop_front());
    end
`ifdef FIFO_READER_STATS_EN
    if (exp_pop && exp_cnt < CNT_MAX) exp_cnt++;
`endif
    #2;
  endtask

  // data_o must hold while a beat is offered but not taken.
  logic        hold_prev = 1'b0;
  logic [31:0] data_prev = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        compared++;
        if (bus.data !== data_prev) begin
          mismatched++;
          $display("FAIL stable_data: data_o=%h required %h", bus.data, data_prev);
        end
      end
      hold_prev = bus.valid & ~bus.ready & ~flush;
      data_prev = bus.data;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = 32'h5A;
    bus.ready      = 1'b1;
    #3;
    compared += 4;
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    if (bus.data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0", bus.data); end
    if (bus.occupancy !== 2'd0) begin mismatched++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    if (bus.fifo_pop !== 1'b0) begin mismatched++; $display("FAIL reset_pop: got %b want 0", bus.fifo_pop); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    mbuf.delete();
    src.delete();
`ifdef FIFO_READER_STATS_EN
    exp_cnt = 0;
    compared++;
    if (pop_count !== '0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", pop_count); end
`endif
  endtask

  task automatic test_first_pop();
    src.push_back(32'hA5);
    tick(1'b0, 1'b0);
    compared += 3;
    if (pre_pop !== 1'b1) begin mismatched++; $display("FAIL first_pop: got %b want 1", pre_pop); end
    if (bus.valid !== 1'b1) begin mismatched++; $display("FAIL first_valid: got %b want 1", bus.valid); end
    if (bus.data !== 32'hA5) begin mismatched++; $display("FAIL first_data: got %h want a5", bus.data); end
    tick(1'b0, 1'b1);
    compared++;
    if (bus.occupancy !== 2'd0) begin mismatched++; $display("FAIL first_drain: occ %0d want 0", bus.occupancy); end
  endtask

  task automatic test_stream();
    for (int unsigned i = 1; i <= 8; i++) src.push_back(i);
    for (int unsigned i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1);
      compared += 4;
      if (pre_pop !== 1'b1) begin mismatched++; $display("FAIL stream_pop[%0d]: got %b want 1", i, pre_pop); end
      if (bus.valid !== 1'b1) begin mismatched++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.valid); end
      if (bus.data !== 32'(i)) begin mismatched++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.data, i); end
      if (bus.occupancy !== 2'd1) begin mismatched++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, bus.occupancy); end
    end
    tick(1'b0, 1'b1);
    compared++;
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL stream_end: valid %b want 0", bus.valid); end
  endtask

  task automatic test_stall();
    int npop = 0;
    for (int unsigned i = 1; i <= 8; i++) src.push_back(i);
    for (int unsigned c = 0; c < 5; c++) begin
      tick(1'b0, 1'b0);
      npop += int'(pre_pop);
    end
    compared += 3;
    if (npop != 2) begin mismatched++; $display("FAIL stall_pops: got %0d want 2", npop); end
    if (bus.occupancy !== 2'd2) begin mismatched++; $display("FAIL stall_occ: got %0d want 2", bus.occupancy); end
    if (bus.data !== 32'h1) begin mismatched++; $display("FAIL stall_data: got %h want 1", bus.data); end
    for (int unsigned i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1);
      compared += 2;
      if (pre_valid !== 1'b1) begin mismatched++; $display("FAIL release_valid[%0d]: got %b want 1", i, pre_valid); end
      if (pre_data !== 32'(i)) begin mismatched++; $display("FAIL release_data[%0d]: got %h want %h", i, pre_data, i); end
    end
    compared++;
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL release_end: valid %b want 0", bus.valid); end
  endtask

  task automatic test_flush();
    src.push_back(32'h10); src.push_back(32'h11); src.push_back(32'h12);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    compared++;
    if (bus.occupancy !== 2'd2) begin mismatched++; $display("FAIL flush_pre_occ: got %0d want 2", bus.occupancy); end
    tick(1'b1, 1'b0);
    compared += 3;
    if (pre_pop !== 1'b0) begin mismatched++; $display("FAIL flush_pop: got %b want 0", pre_pop); end
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %b want 0", bus.valid); end
    if (bus.occupancy !== 2'd0) begin mismatched++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy); end
    tick(1'b0, 1'b0);
    compared++;
    if (bus.data !== 32'h12) begin mismatched++; $display("FAIL flush_next: got %h want 12", bus.data); end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    src.push_back(32'h20); src.push_back(32'h21); src.push_back(32'h22);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    compared++;
    if (bus.occupancy !== 2'd2) begin mismatched++; $display("FAIL arst_pre_occ: got %0d want 2", bus.occupancy); end
    #1 rst_n = 1'b0;
    #1;
    compared += 4;
    if (bus.valid !== 1'b0) begin mismatched++; $display("FAIL arst_valid: got %b want 0", bus.valid); end
    if (bus.data !== 32'h0) begin mismatched++; $display("FAIL arst_data: got %h want 0", bus.data); end
    if (bus.fifo_pop !== 1'b0) begin mismatched++; $display("FAIL arst_pop: got %b want 0", bus.fifo_pop); end
    if (bus.occupancy !== 2'd0) begin mismatched++; $display("FAIL arst_occ: got %0d want 0", bus.occupancy); end
    mbuf.delete();
    src.delete();
`ifdef FIFO_READER_STATS_EN
    exp_cnt = 0;
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

`ifdef FIFO_READER_STATS_EN
  task automatic test_stats();
    for (int unsigned i = 0; i < 22; i++) src.push_back($urandom);
    for (int unsigned i = 0; i < 20; i++) tick(1'b0, 1'b1);
    compared++;
    if (pop_count !== 4'd15) begin mismatched++; $display("FAIL stats_sat: got %0d want 15", pop_count); end
    tick(1'b1, 1'b1);
    compared++;
    if (pop_count !== 4'd15) begin mismatched++; $display("FAIL stats_flush: got %0d want 15", pop_count); end
    src.delete();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
  endtask
`endif

  task automatic test_random();
    for (int unsigned c = 0; c < 400; c++) begin
      if (($urandom % 3 != 0) && (src.size() < 6)) src.push_back($urandom);
      tick(($urandom % 20) == 0, ($urandom % 4) != 0);
      compared += 3;
      if (pre_pop !== exp_pop) begin mismatched++; $display("FAIL rand_pop[%0d]: got %b want %b", c, pre_pop, exp_pop); end
      if (bus.valid !== (mbuf.size() != 0)) begin mismatched++; $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.valid, mbuf.size() != 0); end
      if (bus.occupancy !== 2'(mbuf.size())) begin mismatched++; $display("FAIL rand_occ[%0d]: got %0d want %0d", c, bus.occupancy, mbuf.size()); end
      if (mbuf.size() != 0) begin
        compared++;
        if (bus.data !== mbuf[0]) begin mismatched++; $display("FAIL rand_data[%0d]: got %h want %h", c, bus.data, mbuf[0]); end
      end
`ifdef FIFO_READER_STATS_EN
      compared++;
      if (int'(pop_count) != exp_cnt) begin mismatched++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, pop_count, exp_cnt); end
`endif
    end
  endtask

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.ready      = 1'b0;
    test_reset();
    test_first_pop();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
`ifdef FIFO_READER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
